// File: rtl/player_physics.sv
// Player sprite physics: key-driven STAND/RUN/CROUCH/AIM_UP/JUMP states, X motion, gravity, lives.
// Optional feature macro PLAYER_JUMP_EN builds the JUMP state, gravity and the vertical velocity register.
module player_physics #(
    parameter int W          = 10,
    parameter int X_START    = 30,
    parameter int GROUND_Y   = 230,
    parameter int X_MIN      = 0,
    parameter int X_MAX      = 639,
    parameter int X_STEP     = 2,
    parameter int JUMP_V     = 12,
    parameter int GRAVITY    = 1,
    parameter int INV_FRAMES = 60
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         frame_tick,
    input  logic         keyPress,
    input  logic [7:0]   keycode,
    input  logic         game_active,
    input  logic         hit,
    output logic [W-1:0] PlayerX,
    output logic [W-1:0] PlayerY,
    output logic [W-1:0] PlayerHeight,
    output logic [W-1:0] PlayerWidth,
    output logic         Direction,
    output logic         playerMoving,
    output logic         airborne,
    output logic [1:0]   Lives,
    output logic         dead
);
    localparam logic [2:0] ST_STAND  = 3'd0;
    localparam logic [2:0] ST_RUN    = 3'd1;
    localparam logic [2:0] ST_CROUCH = 3'd2;
    localparam logic [2:0] ST_AIM    = 3'd3;
    localparam logic [2:0] ST_JUMP   = 3'd4;

    localparam int            CW     = $clog2(INV_FRAMES + 2);
    localparam logic [CW-1:0] INV_L  = CW'(INV_FRAMES);
    localparam logic [W-1:0]  XS_L   = W'(X_START);
    localparam logic [W-1:0]  GY_L   = W'(GROUND_Y);
    localparam logic [W:0]    XMIN_E = (W+1)'(X_MIN);
    localparam logic [W:0]    XMAX_E = (W+1)'(X_MAX);
    localparam logic [W:0]    STEP_E = (W+1)'(X_STEP);

    logic [2:0]    r_state, w_state_nx, w_gnd_state;
    logic [W-1:0]  r_x, w_x_nx;
    logic [W:0]    w_xc, w_lim;
    logic          r_dir, r_mov, r_hit_pend;
    logic [1:0]    r_lives;
    logic [CW-1:0] r_inv;
    logic          w_kv, w_up, w_left, w_down, w_right, w_jump, w_horiz;

    function automatic logic [W-1:0] f_height(input logic [2:0] s);
        case (s)
            ST_AIM:    f_height = W'(45);
            ST_CROUCH: f_height = W'(34);
            default:   f_height = W'(33);
        endcase
    endfunction

    function automatic logic [W-1:0] f_width(input logic [2:0] s);
        case (s)
            ST_AIM:    f_width = W'(14);
            ST_CROUCH: f_width = W'(17);
            default:   f_width = W'(24);
        endcase
    endfunction

    assign w_kv    = keyPress & game_active;
    assign w_up    = w_kv & (keycode == 8'h1D);
    assign w_left  = w_kv & (keycode == 8'h1C);
    assign w_down  = w_kv & (keycode == 8'h1B);
    assign w_right = w_kv & (keycode == 8'h23);
`ifdef PLAYER_JUMP_EN
    assign w_jump  = w_kv & (keycode == 8'h29);
`else
    assign w_jump  = 1'b0;
`endif

    assign dead    = (r_lives == 2'd0);
    assign w_horiz = (w_left | w_right) & ~dead;

    // State a grounded player (or one just landing) moves to from the current key
    always_comb begin
        w_gnd_state = ST_STAND;
        if (!dead) begin
            if (w_jump)                 w_gnd_state = ST_JUMP;
            else if (w_left | w_right)  w_gnd_state = ST_RUN;
            else if (w_down)            w_gnd_state = ST_CROUCH;
            else if (w_up)              w_gnd_state = ST_AIM;
        end
    end

`ifdef PLAYER_JUMP_EN
    localparam logic signed [W-1:0]   JV_S = W'(-JUMP_V);
    localparam logic signed [W-1:0]   GR_S = W'(GRAVITY);
    localparam logic signed [W+1:0]   GY_S = (W+2)'(GROUND_Y);

    logic signed [W-1:0] r_vy, w_vy_nx;
    logic [W-1:0]        r_y, w_y_nx;
    logic signed [W+1:0] w_ysum;

    assign w_ysum = $signed({2'b00, r_y}) + $signed({{2{r_vy[W-1]}}, r_vy});

    always_comb begin
        w_state_nx = r_state;
        w_y_nx     = r_y;
        w_vy_nx    = r_vy;
        if (r_state != ST_JUMP) begin
            w_state_nx = w_gnd_state;
            if (w_gnd_state == ST_JUMP) w_vy_nx = JV_S;
        end else if (!r_vy[W-1] && (r_vy != '0) && (w_ysum >= GY_S)) begin
            w_state_nx = w_gnd_state;
            w_y_nx     = GY_L;
            w_vy_nx    = (w_gnd_state == ST_JUMP) ? JV_S : '0;
        end else if (w_ysum[W+1]) begin
            w_y_nx  = '0;
            w_vy_nx = '0;
        end else begin
            w_y_nx  = w_ysum[W-1:0];
            w_vy_nx = r_vy + GR_S;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_y  <= GY_L;
            r_vy <= '0;
        end else if (frame_tick) begin
            r_y  <= w_y_nx;
            r_vy <= w_vy_nx;
        end
    end

    assign PlayerY  = r_y;
    assign airborne = (r_state == ST_JUMP);
`else
    assign w_state_nx = w_gnd_state;
    assign PlayerY    = GY_L;
    assign airborne   = 1'b0;
`endif

    // Clamp against the right edge using the box of the state being entered
    always_comb begin
        w_lim = XMAX_E + (W+1)'(1) - {1'b0, f_width(w_state_nx)};
        if (w_right)
            w_xc = {1'b0, r_x} + STEP_E;
        else if ({1'b0, r_x} < XMIN_E + STEP_E)
            w_xc = XMIN_E;
        else
            w_xc = {1'b0, r_x} - STEP_E;
        if (w_xc > w_lim)  w_xc = w_lim;
        if (w_xc < XMIN_E) w_xc = XMIN_E;
        w_x_nx = w_horiz ? w_xc[W-1:0] : r_x;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_STAND;
            r_x     <= XS_L;
            r_dir   <= 1'b0;
            r_mov   <= 1'b0;
        end else if (frame_tick) begin
            r_state <= w_state_nx;
            r_x     <= w_x_nx;
            r_mov   <= (w_x_nx != r_x);
            if (w_horiz) r_dir <= w_left;
        end
    end

    // Hits between ticks are latched; a hit on the tick itself applies immediately
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_hit_pend <= 1'b0;
            r_lives    <= 2'd3;
            r_inv      <= '0;
        end else if (frame_tick) begin
            r_hit_pend <= 1'b0;
            if ((r_hit_pend | hit) && (r_inv == '0) && (r_lives != 2'd0)) begin
                r_lives <= r_lives - 2'd1;
                r_inv   <= INV_L;
            end else if (r_inv != '0) begin
                r_inv <= r_inv - CW'(1);
            end
        end else if (hit) begin
            r_hit_pend <= 1'b1;
        end
    end

    assign PlayerX      = r_x;
    assign PlayerHeight = f_height(r_state);
    assign PlayerWidth  = f_width(r_state);
    assign Direction    = r_dir;
    assign playerMoving = r_mov;
    assign Lives        = r_lives;
endmodule

// File: tb/tb_player_physics.sv
// Scoreboard bench for player_physics: a frame-level reference model queues expected outputs per tick.
module tb_player_physics;
    localparam int W = 10;
`ifdef PLAYER_JUMP_EN
    localparam bit JUMP_EN = 1'b1;
`else
    localparam bit JUMP_EN = 1'b0;
`endif
    localparam int M_STAND = 0, M_RUN = 1, M_CROUCH = 2, M_AIM = 3, M_JUMP = 4;

    logic         Clk = 0, Reset = 0, frame_tick = 0, keyPress = 0, game_active = 1, hit = 0;
    logic [7:0]   keycode = 8'h00;
    logic [W-1:0] PlayerX, PlayerY, PlayerHeight, PlayerWidth;
    logic         Direction, playerMoving, airborne, dead;
    logic [1:0]   Lives;

    always #5 Clk = ~Clk;

    player_physics dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .keyPress(keyPress),
        .keycode(keycode), .game_active(game_active), .hit(hit),
        .PlayerX(PlayerX), .PlayerY(PlayerY), .PlayerHeight(PlayerHeight),
        .PlayerWidth(PlayerWidth), .Direction(Direction), .playerMoving(playerMoving),
        .airborne(airborne), .Lives(Lives), .dead(dead)
    );

    typedef struct packed {
        logic [9:0] x, y, h, w;
        logic       dir, mov, air;
        logic [1:0] lives;
        logic       dead;
    } obs_t;

    obs_t q[$];
    int   n_chk = 0, n_fail = 0;
    logic tick_d = 0;

    int m_x, m_y, m_vy, m_mode, m_lives, m_inv;
    bit m_dir, m_mov, m_pend;

    function automatic int box_h(input int mode);
        return (mode == M_AIM) ? 45 : (mode == M_CROUCH) ? 34 : 33;
    endfunction
    function automatic int box_w(input int mode);
        return (mode == M_AIM) ? 14 : (mode == M_CROUCH) ? 17 : 24;
    endfunction

    function automatic obs_t m_obs();
        obs_t o;
        o.x = 10'(m_x); o.y = 10'(m_y); o.h = 10'(box_h(m_mode)); o.w = 10'(box_w(m_mode));
        o.dir = m_dir; o.mov = m_mov; o.air = (m_mode == M_JUMP);
        o.lives = 2'(m_lives); o.dead = (m_lives == 0);
        return o;
    endfunction

    function automatic obs_t cur_obs();
        obs_t o;
        o.x = PlayerX; o.y = PlayerY; o.h = PlayerHeight; o.w = PlayerWidth;
        o.dir = Direction; o.mov = playerMoving; o.air = airborne;
        o.lives = Lives; o.dead = dead;
        return o;
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got x=%0d y=%0d box=%0dx%0d dir=%0d mov=%0d air=%0d lives=%0d dead=%0d, want x=%0d y=%0d box=%0dx%0d dir=%0d mov=%0d air=%0d lives=%0d dead=%0d",
                     name, got.x, got.y, got.h, got.w, got.dir, got.mov, got.air, got.lives, got.dead,
                     exp.x, exp.y, exp.h, exp.w, exp.dir, exp.mov, exp.air, exp.lives, exp.dead);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    task automatic m_reset();
        m_x = 30; m_y = 230; m_vy = 0; m_mode = M_STAND; m_lives = 3; m_inv = 0;
        m_dir = 0; m_mov = 0; m_pend = 0;
    endtask

    // One frame of the game rules, written from the behavioural description
    task automatic m_step(input logic [7:0] kc, input bit kp, input bit ga, input bit h);
        int k, gnd, nx, lim;
        bit l, r, u, d, j, dd;
        k  = (kp && ga) ? int'(kc) : -1;
        l  = (k == 'h1C); r = (k == 'h23); d = (k == 'h1B); u = (k == 'h1D);
        j  = JUMP_EN && (k == 'h29);
        dd = (m_lives == 0);
        gnd = dd ? M_STAND : j ? M_JUMP : (l || r) ? M_RUN : d ? M_CROUCH : u ? M_AIM : M_STAND;
        if (m_mode != M_JUMP) begin
            m_mode = gnd;
            if (gnd == M_JUMP) m_vy = -12;
        end else if (m_vy > 0 && m_y + m_vy >= 230) begin
            m_y = 230; m_mode = gnd;
            m_vy = (gnd == M_JUMP) ? -12 : 0;
        end else if (m_y + m_vy < 0) begin
            m_y = 0; m_vy = 0;
        end else begin
            m_y = m_y + m_vy; m_vy = m_vy + 1;
        end
        m_mov = 0;
        if (!dd && (l || r)) begin
            lim = 639 - box_w(m_mode) + 1;
            nx  = r ? m_x + 2 : m_x - 2;
            if (nx > lim) nx = lim;
            if (nx < 0) nx = 0;
            m_mov = (nx != m_x); m_x = nx; m_dir = l;
        end
        if ((m_pend || h) && m_inv == 0 && m_lives > 0) begin
            m_lives--; m_inv = 60;
        end else if (m_inv > 0) m_inv--;
        m_pend = 0;
    endtask

    task automatic tick(input logic [7:0] kc, input bit kp, input bit ga, input bit h);
        @(negedge Clk);
        keycode = kc; keyPress = kp; game_active = ga; hit = h; frame_tick = 1;
        m_step(kc, kp, ga, h);
        q.push_back(m_obs());
        @(negedge Clk);
        frame_tick = 0; hit = 0;
    endtask

    task automatic idle(input bit h);
        @(negedge Clk);
        frame_tick = 0; hit = h;
        if (h) m_pend = 1;
        @(negedge Clk);
        hit = 0;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1; frame_tick = 0; hit = 0; keyPress = 0;
        #1;
        m_reset();
        check("reset", cur_obs(), m_obs());
        @(negedge Clk);
        Reset = 0;
    endtask

    always @(posedge Clk) tick_d <= frame_tick & ~Reset;

    always @(negedge Clk) begin
        if (tick_d) begin
            if (q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL scoreboard: frame output with no expected entry");
            end else begin
                check("frame", cur_obs(), q.pop_front());
            end
        end
    end

    logic [7:0] codes [7] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29, 8'h00, 8'h5A};

    initial begin
        int peak, lt;
        do_reset();

        for (int i = 0; i < 10; i++) tick(8'h23, 1, 1, 0);
        chk_int("run_right_x", PlayerX, 50);
        chk_int("run_right_dir", Direction, 0);
        chk_int("run_right_mov", playerMoving, 1);

        do_reset();
        for (int i = 0; i < 14; i++) tick(8'h1C, 1, 1, 0);
        chk_int("walk_to_2", PlayerX, 2);
        tick(8'h1C, 1, 1, 0);
        chk_int("left_clamp_x", PlayerX, 0);
        for (int i = 0; i < 2; i++) begin
            tick(8'h1C, 1, 1, 0);
            chk_int("left_wall_mov", playerMoving, 0);
        end
        chk_int("left_wall_dir", Direction, 1);

        do_reset();
        for (int i = 0; i < 3; i++) tick(8'h1D, 1, 1, 0);
        chk_int("aim_h", PlayerHeight, 45);
        chk_int("aim_w", PlayerWidth, 14);
        chk_int("aim_x", PlayerX, 30);
        tick(8'h1B, 1, 1, 0);
        chk_int("crouch_h", PlayerHeight, 34);
        chk_int("crouch_w", PlayerWidth, 17);
        tick(8'h1B, 1, 0, 0);
        chk_int("inactive_stand_h", PlayerHeight, 33);

        do_reset();
        tick(8'h29, 1, 1, 0);
        if (JUMP_EN) begin
            chk_int("jump_air", airborne, 1);
            tick(8'h00, 0, 1, 0); chk_int("jump_y1", PlayerY, 218);
            tick(8'h00, 0, 1, 0); chk_int("jump_y2", PlayerY, 207);
            tick(8'h00, 0, 1, 0); chk_int("jump_y3", PlayerY, 197);
            do_reset();
            chk_int("reset_midjump_y", PlayerY, 230);
            chk_int("reset_midjump_air", airborne, 0);
            tick(8'h29, 1, 1, 0);
            peak = 230; lt = 0;
            while (airborne && lt < 40) begin
                tick(8'h00, 0, 1, 0);
                if (PlayerY < peak) peak = PlayerY;
                lt++;
            end
            chk_int("jump_landed_in_budget", (lt < 40) ? 1 : 0, 1);
            chk_int("jump_peak", peak, 152);
            chk_int("jump_land_y", PlayerY, 230);
        end else begin
            chk_int("nojump_y", PlayerY, 230);
            chk_int("nojump_air", airborne, 0);
        end

        do_reset();
        for (int i = 0; i <= 61; i++) begin
            tick(8'h00, 0, 1, (i == 0 || i == 10 || i == 59 || i == 61));
            if (i == 0)  chk_int("hit_t0", Lives, 2);
            if (i == 10) chk_int("hit_t10", Lives, 2);
            if (i == 59) chk_int("hit_t59", Lives, 2);
            if (i == 61) chk_int("hit_t61", Lives, 1);
        end
        for (int i = 0; i < 60; i++) tick(8'h00, 0, 1, 0);
        idle(1);
        tick(8'h00, 0, 1, 0);
        chk_int("captured_hit_dead", dead, 1);
        tick(8'h23, 1, 1, 0);
        chk_int("dead_no_move", PlayerX, 30);

        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (i % 150 == 149) do_reset();
            if ($urandom_range(3) == 0) idle($urandom_range(2) == 0);
            tick(codes[$urandom_range(6)], $urandom_range(4) != 0,
                 $urandom_range(7) != 0, $urandom_range(15) == 0);
        end

        repeat (3) @(negedge Clk);
        chk_int("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
